// File: rtl/arbitro_rr_pkg.sv
// flow_defs: shared definitions for the flow-control round-robin arbiter.
//   estado_t        - arbiter state encoding (RESET/ACTIVE/PAUSE/ERROR)
//   N_LANES         - number of upstream lane FIFOs
//   DATA_W_DEFAULT  - default lane word width
package flow_defs;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ERROR  = 2'd3
    } estado_t;

    localparam int N_LANES        = 4;
    localparam int DATA_W_DEFAULT = 6;

endpackage

// File: rtl/arbitro_rr_if.sv
// arbitro_rr_if: lane-FIFO / downstream-FIFO bus seen by the arbiter.
//   empty[3:0], data_in0..3     - lane FIFO status and read data
//   pop[3:0]                    - one-hot lane read strobe
//   full_out, almost_full_out   - downstream FIFO status
//   push_out, data_out          - downstream write strobe and data
// Modports: master = arbiter side, slave = FIFO/environment side.
interface arbitro_rr_if #(parameter int DATA_W = flow_defs::DATA_W_DEFAULT);
    import flow_defs::*;

    logic [N_LANES-1:0] empty;
    logic [DATA_W-1:0]  data_in0;
    logic [DATA_W-1:0]  data_in1;
    logic [DATA_W-1:0]  data_in2;
    logic [DATA_W-1:0]  data_in3;
    logic [N_LANES-1:0] pop;
    logic               full_out;
    logic               almost_full_out;
    logic               push_out;
    logic [DATA_W-1:0]  data_out;

    modport master (
        input  empty, data_in0, data_in1, data_in2, data_in3,
        input  full_out, almost_full_out,
        output pop, push_out, data_out
    );

    modport slave (
        output empty, data_in0, data_in1, data_in2, data_in3,
        output full_out, almost_full_out,
        input  pop, push_out, data_out
    );

endinterface

// File: rtl/arbitro_rr_select.sv
// rr_select: combinational round-robin pick.
//   req[3:0]       - lane request vector (~empty)
//   ultimo[1:0]    - last granted lane; search starts at ultimo+1
//   grant[3:0]     - one-hot grant (zero when no request)
//   grant_idx[1:0] - index of granted lane
//   grant_valid    - at least one lane requested
module rr_select
    import flow_defs::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [1:0]         ultimo,
    output logic [N_LANES-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_valid
);

    logic [1:0] cand_s;
    logic       hit_s;

    // Walk ultimo+1 .. ultimo+4 (2-bit wrap) and keep the first requester.
    always_comb begin
        grant       = 4'b0000;
        grant_idx   = ultimo;
        grant_valid = 1'b0;
        cand_s      = 2'd0;
        hit_s       = 1'b0;
        for (int k = 1; k <= N_LANES; k++) begin
            cand_s      = ultimo + 2'(k);
            hit_s       = ~grant_valid & req[cand_s];
            grant       = hit_s ? (4'b0001 << cand_s) : grant;
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | req[cand_s];
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin pop arbiter from four lane FIFOs into one
// downstream FIFO, gated by the flow-control FSM (pausa/continuar/error_full).
//   clk, rst (sync, active-low), enb
//   bus       - arbitro_rr_if.master (empty, data_in0..3, pop, full_out,
//               almost_full_out, push_out, data_out)
//   pausa, continuar, error_full - flow-control FSM requests
//   err       - sticky error, estado - current state (debug)
// Optional: ARB_CONTADORES_EN adds cuenta0..3, 8-bit per-lane push counters.
// Latency pop -> push_out is 2 cycles; at most two words are in flight.
module arbitro_rr
    import flow_defs::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [N_LANES-1:0] pausa,
    input  logic [N_LANES-1:0] continuar,
    input  logic               error_full,
    arbitro_rr_if.master       bus,
    output logic               err,
    output logic [1:0]         estado
`ifdef ARB_CONTADORES_EN
    ,
    output logic [7:0]         cuenta0,
    output logic [7:0]         cuenta1,
    output logic [7:0]         cuenta2,
    output logic [7:0]         cuenta3
`endif
);

    estado_t            estado_r;
    logic               err_r;
    logic [1:0]         ultimo_r;
    logic               s1_valid_r;
    logic [1:0]         s1_lane_r;
    logic               push_r;
    logic [DATA_W-1:0]  data_r;
    logic [N_LANES-1:0] req_s;
    logic [N_LANES-1:0] grant_s;
    logic [1:0]         grant_idx_s;
    logic               grant_valid_s;
    logic               eligible_s;
    logic               fire_s;
    logic [N_LANES-1:0] pop_s;
    logic [DATA_W-1:0]  lane_data_s;

    assign req_s = ~bus.empty;

    rr_select u_rr_select (
        .req         (req_s),
        .ultimo      (ultimo_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Both downstream flags block grants: the in-flight pipeline needs two free slots.
    assign eligible_s = (estado_r == ST_ACTIVE) & enb & ~bus.full_out & ~bus.almost_full_out;

    // Gate the round-robin pick with eligibility to form the pop strobe.
    always_comb begin
        pop_s  = 4'b0000;
        fire_s = 1'b0;
        if (eligible_s && grant_valid_s) begin
            pop_s  = grant_s;
            fire_s = 1'b1;
        end else begin
            pop_s  = 4'b0000;
            fire_s = 1'b0;
        end
    end

    // Select the read data of the lane popped one cycle earlier.
    always_comb begin
        lane_data_s = bus.data_in0;
        case (s1_lane_r)
            2'd0:    lane_data_s = bus.data_in0;
            2'd1:    lane_data_s = bus.data_in1;
            2'd2:    lane_data_s = bus.data_in2;
            2'd3:    lane_data_s = bus.data_in3;
            default: lane_data_s = bus.data_in0;
        endcase
    end

    // Arbiter state machine with sticky error flag; error beats pause.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_r <= ST_RESET;
            err_r    <= 1'b0;
        end else begin
            case (estado_r)
                ST_RESET: estado_r <= ST_ACTIVE;
                ST_ACTIVE: begin
                    if (error_full) begin
                        estado_r <= ST_ERROR;
                        err_r    <= 1'b1;
                    end else if ((|pausa) && !(|continuar)) begin
                        estado_r <= ST_PAUSE;
                    end else begin
                        estado_r <= ST_ACTIVE;
                    end
                end
                ST_PAUSE: begin
                    if (error_full) begin
                        estado_r <= ST_ERROR;
                        err_r    <= 1'b1;
                    end else if ((|continuar) || !(|pausa)) begin
                        estado_r <= ST_ACTIVE;
                    end else begin
                        estado_r <= ST_PAUSE;
                    end
                end
                ST_ERROR: estado_r <= ST_ERROR;
                default:  estado_r <= ST_RESET;
            endcase
        end
    end

    // Round-robin pointer follows the last granted lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ultimo_r <= 2'd3;
        end else if (fire_s) begin
            ultimo_r <= grant_idx_s;
        end else begin
            ultimo_r <= ultimo_r;
        end
    end

    // Two-stage in-flight pipeline; independent of state so popped words always drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_lane_r  <= 2'd0;
            push_r     <= 1'b0;
            data_r     <= '0;
        end else begin
            s1_valid_r <= fire_s;
            s1_lane_r  <= fire_s ? grant_idx_s : s1_lane_r;
            push_r     <= s1_valid_r;
            data_r     <= s1_valid_r ? lane_data_s : data_r;
        end
    end

`ifdef ARB_CONTADORES_EN
    logic [1:0] s2_lane_r;
    logic [7:0] cnt_r [N_LANES];

    // Per-lane push counters, wrapping at 255 and frozen while enb is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_lane_r <= 2'd0;
            for (int i = 0; i < N_LANES; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            s2_lane_r <= s1_valid_r ? s1_lane_r : s2_lane_r;
            if (push_r && enb) begin
                cnt_r[s2_lane_r] <= cnt_r[s2_lane_r] + 8'd1;
            end else begin
                cnt_r[s2_lane_r] <= cnt_r[s2_lane_r];
            end
        end
    end

    assign cuenta0 = cnt_r[0];
    assign cuenta1 = cnt_r[1];
    assign cuenta2 = cnt_r[2];
    assign cuenta3 = cnt_r[3];
`endif

    assign bus.pop      = pop_s;
    assign bus.push_out = push_r;
    assign bus.data_out = data_r;
    assign err          = err_r;
    assign estado       = estado_r;

endmodule
